// File: rtl/basic_cpu_core.sv
// basic_cpu_core: multi-cycle accumulator CPU for the basic-computer ISA.
// Memory-reference instructions (direct/indirect), register-reference ops,
// skips and HLT, with a ready/wait-state handshake to an external SRAM.
module basic_cpu_core #(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DWIDTH-1:0]     i_data,
  input  logic                  i_ready,
  output logic [DWIDTH-1:0]     o_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_we,
  output logic                  o_ce,
  output logic                  o_halt,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [DWIDTH-1:0]     o_ac,
  output logic                  o_e
);

  localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] A_ONE   = ADDR_WIDTH'(1);
  localparam logic [DWIDTH-1:0]     D_ONE   = DWIDTH'(1);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_INDIR, S_READ, S_ALU, S_WRITE, S_EXEC, S_HALT
  } state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   pc, ar;
  logic [DWIDTH-1:0]       ac, dr, ir;
  logic                    e;

  // Instruction fields
  logic                    ind;
  logic [2:0]              op;
  logic [ADDR_WIDTH-1:0]   adr;
  assign ind = ir[DWIDTH-1];
  assign op  = ir[DWIDTH-2 -: 3];
  assign adr = ir[ADDR_WIDTH-1:0];

  // Register-reference results
  logic [DWIDTH-1:0]       rr_ac;
  logic                    rr_e;
  logic                    rr_skip;

  // Operand phase an opcode needs once its effective address is known
  function automatic state_t dispatch(input logic [2:0] opc);
    case (opc)
      3'd0, 3'd1, 3'd2, 3'd6: dispatch = S_READ;
      3'd3, 3'd5:             dispatch = S_WRITE;
      default:                dispatch = S_EXEC;
    endcase
  endfunction

  // State register; reset drops any in-flight access immediately
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!reset_n) state <= S_RST;
    else          state <= next_state;
  end

  // Next-state and memory-port outputs
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    next_state = state;
    o_ce       = 1'b0;
    o_we       = 1'b0;
    o_data     = '0;
    o_addr     = ar;
    case (state)
      S_RST: begin
        o_addr     = pc;
        next_state = S_FETCH;
      end
      S_FETCH: begin
        o_ce   = 1'b1;
        o_addr = pc;
        if (i_ready) next_state = S_DECODE;
      end
      S_DECODE: next_state = (ind && op != 3'd7) ? S_INDIR : dispatch(op);
      S_INDIR: begin
        o_ce = 1'b1;
        if (i_ready) next_state = dispatch(op);
      end
      S_READ: begin
        o_ce = 1'b1;
        if (i_ready) next_state = S_ALU;
      end
      S_ALU: next_state = (op == 3'd6) ? S_WRITE : S_FETCH;
      S_WRITE: begin
        o_ce = 1'b1;
        o_we = 1'b1;
        case (op)
          3'd3:    o_data = ac;
          3'd5:    o_data = DWIDTH'(pc);
          default: o_data = dr;
        endcase
        if (i_ready) next_state = S_FETCH;
      end
      S_EXEC: next_state = (op == 3'd7 && !ind && ir[0]) ? S_HALT : S_FETCH;
      S_HALT: next_state = S_HALT;
      default: next_state = S_RST;
    endcase
  end

  // Register-reference chain: CLA, CLE, CMA, CME, CIR, CIL, INC in order;
  // skips look at the pre-instruction AC/E
  always_comb begin
    rr_ac = ac;
    rr_e  = e;
    if (ir[11]) rr_ac = '0;
    if (ir[10]) rr_e  = 1'b0;
    if (ir[9])  rr_ac = ~rr_ac;
    if (ir[8])  rr_e  = ~rr_e;
    if (ir[7])  {rr_ac, rr_e} = {rr_e, rr_ac};
    if (ir[6])  {rr_e, rr_ac} = {rr_ac, rr_e};
    if (ir[5])  rr_ac = rr_ac + D_ONE;
    rr_skip = (ir[4] && !ac[DWIDTH-1]) || (ir[3] && ac[DWIDTH-1]) ||
              (ir[2] && ac == '0)      || (ir[1] && !e);
  end

  // Datapath registers, updated per state; accesses commit only on i_ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= PC_INIT;
      ar <= '0;
      ac <= '0;
      dr <= '0;
      ir <= '0;
      e  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (i_ready) begin
          ir <= i_data;
          pc <= pc + A_ONE;
        end
        S_DECODE: ar <= adr;
        S_INDIR:  if (i_ready) ar <= i_data[ADDR_WIDTH-1:0];
        S_READ:   if (i_ready) dr <= i_data;
        S_ALU: begin
          case (op)
            3'd0:    ac <= ac & dr;
            3'd1:    {e, ac} <= {1'b0, ac} + {1'b0, dr};
            3'd2:    ac <= dr;
            3'd6:    dr <= dr + D_ONE;
            default: ;
          endcase
        end
        S_WRITE: if (i_ready) begin
          if (op == 3'd5)                   pc <= ar + A_ONE;
          else if (op == 3'd6 && dr == '0)  pc <= pc + A_ONE;
        end
        S_EXEC: begin
          if (op == 3'd4) begin
            pc <= ar;
          end else if (op == 3'd7 && !ind) begin
            ac <= rr_ac;
            e  <= rr_e;
            if (rr_skip) pc <= pc + A_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_halt = (state == S_HALT);
  assign o_pc   = pc;
  assign o_ac   = ac;
  assign o_e    = e;

endmodule

// File: tb/tb_basic_cpu_core.sv
// Self-checking bench for basic_cpu_core: SRAM model with configurable wait
// states, and an instruction-level reference interpreter of the ISA.
module tb_basic_cpu_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] i_data = '0;
  logic        i_ready = 1'b0;
  logic [15:0] o_data;
  logic [11:0] o_addr;
  logic        o_we, o_ce, o_halt, o_e;
  logic [11:0] o_pc;
  logic [15:0] o_ac;

  basic_cpu_core dut (
    .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_ready(i_ready),
    .o_data(o_data), .o_addr(o_addr), .o_we(o_we), .o_ce(o_ce),
    .o_halt(o_halt), .o_pc(o_pc), .o_ac(o_ac), .o_e(o_e)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // SRAM seen by the DUT, and the reference model's private copy
  logic [15:0] mem   [0:4095];
  logic [15:0] m_mem [0:4095];

  int          wait_states = 0;
  int          wcnt = 0;
  int          stable_bad = 0;
  logic        pend_we = 1'b0;
  logic [11:0] pend_addr = '0;
  logic [15:0] pend_data = '0;
  logic [11:0] lat_addr = '0;
  logic        lat_we = 1'b0;
  logic [15:0] lat_data = '0;

  // SRAM model: each access takes wait_states stall cycles before i_ready;
  // a write is committed once the completing clock edge has passed
  always @(negedge clk) begin
    if (!reset_n) begin
      i_ready = 1'b0;
      wcnt    = 0;
    end else begin
      if (i_ready) begin
        if (pend_we) mem[pend_addr] = pend_data;
        wcnt = 0;
      end
      i_ready = 1'b0;
      if (o_ce) begin
        if (wcnt == 0) begin
          lat_addr = o_addr; lat_we = o_we; lat_data = o_data;
        end else if (o_addr !== lat_addr || o_we !== lat_we || o_data !== lat_data) begin
          stable_bad++;
        end
        if (wcnt == wait_states) begin
          i_ready   = 1'b1;
          i_data    = mem[o_addr];
          pend_we   = o_we;
          pend_addr = o_addr;
          pend_data = o_data;
        end else begin
          wcnt++;
          i_data = 16'($urandom);
        end
      end
    end
  end

  // Reference interpreter state
  logic [11:0] m_pc;
  logic [15:0] m_ac;
  logic        m_e;

  // Executes the program in m_mem instruction by instruction; cyc counts the
  // RST cycle plus every state cycle and wait cycle the program should take
  task automatic model_run(input int w, output int cyc, output bit halted);
    logic [15:0] ir, dr;
    logic [11:0] ea;
    logic [16:0] x;
    logic [2:0]  op;
    bit          sk;
    int          s;
    m_pc = '0; m_ac = '0; m_e = 1'b0;
    cyc = 1; halted = 0;
    for (int n = 0; n < 100 && !halted; n++) begin
      ir = m_mem[m_pc];
      m_pc = m_pc + 12'd1;
      op = ir[14:12];
      ea = ir[11:0];
      cyc += (1 + w) + 1;                      // fetch + decode
      if (op == 3'd7) begin
        cyc += 1;
        if (!ir[15]) begin
          sk = (ir[4] && !m_ac[15]) || (ir[3] && m_ac[15]) ||
               (ir[2] && m_ac == 16'd0) || (ir[1] && !m_e);
          if (ir[11]) m_ac = '0;
          if (ir[10]) m_e = 1'b0;
          if (ir[9])  m_ac = ~m_ac;
          if (ir[8])  m_e = ~m_e;
          x = {m_ac, m_e};
          if (ir[7]) x = {x[0], x[16:1]};
          if (ir[6]) x = {x[15:0], x[16]};
          m_ac = x[16:1];
          m_e  = x[0];
          if (ir[5]) m_ac = m_ac + 16'd1;
          if (sk) m_pc = m_pc + 12'd1;
          if (ir[0]) halted = 1;
        end
      end else begin
        if (ir[15]) begin
          ea = m_mem[ea][11:0];
          cyc += 1 + w;
        end
        case (op)
          3'd0, 3'd1, 3'd2: begin
            dr = m_mem[ea];
            cyc += (1 + w) + 1;
            if (op == 3'd0) m_ac = m_ac & dr;
            else if (op == 3'd2) m_ac = dr;
            else begin
              s = int'(m_ac) + int'(dr);
              m_e  = (s > 65535);
              m_ac = s[15:0];
            end
          end
          3'd3: begin m_mem[ea] = m_ac; cyc += 1 + w; end
          3'd4: begin m_pc = ea; cyc += 1; end
          3'd5: begin
            m_mem[ea] = {4'h0, m_pc};
            m_pc = ea + 12'd1;
            cyc += 1 + w;
          end
          default: begin
            dr = m_mem[ea] + 16'd1;
            m_mem[ea] = dr;
            if (dr == 16'd0) m_pc = m_pc + 12'd1;
            cyc += (1 + w) + 1 + (1 + w);
          end
        endcase
      end
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 4096; a++) mem[a] = '0;
  endtask

  task automatic copy_mem();
    for (int a = 0; a < 4096; a++) m_mem[a] = mem[a];
  endtask

  task automatic apply_reset(input int w);
    wait_states = w;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    stable_bad = 0;
    #1 reset_n = 1'b1;
  endtask

  int last_cyc;

  // Runs the program in mem on both model and DUT and compares final state
  task automatic run_case(input string name, input int w);
    int  mcyc, ncyc, bad;
    bit  mhalt, halted;
    copy_mem();
    model_run(w, mcyc, mhalt);
    apply_reset(w);
    ncyc = 0; halted = 0;
    while (ncyc < 3000 && !halted) begin
      @(negedge clk);
      ncyc++;
      halted = o_halt;
    end
    @(negedge clk);
    last_cyc = ncyc;
    check({name, ".halt"}, halted, mhalt);
    check({name, ".cycles"}, ncyc, mcyc);
    check({name, ".pc"}, o_pc, m_pc);
    check({name, ".ac"}, o_ac, m_ac);
    check({name, ".e"}, o_e, m_e);
    check({name, ".ce_in_halt"}, o_ce, 1'b0);
    bad = 0;
    for (int a = 0; a < 4096; a++) if (mem[a] !== m_mem[a]) bad++;
    check({name, ".mem"}, bad, 0);
    check({name, ".stable"}, stable_bad, 0);
  endtask

  initial begin
    int  n, c;
    bit  h;

    // Reset release: RST cycle has no access, then fetch from 0x000
    clear_mem();
    mem[0] = 16'h7001;
    apply_reset(0);
    #1;
    check("rst.ce", o_ce, 1'b0);
    check("rst.we", o_we, 1'b0);
    check("rst.addr", o_addr, 12'h000);
    check("rst.halt", o_halt, 1'b0);
    check("rst.ac", o_ac, 16'h0000);
    @(posedge clk); #1;
    check("fetch.ce", o_ce, 1'b1);
    check("fetch.addr", o_addr, 12'h000);
    check("fetch.we", o_we, 1'b0);

    // Reset asserted mid-WRITE drops the access and leaves memory untouched
    clear_mem();
    mem[12'h000] = 16'h2010; mem[12'h001] = 16'h3012;
    mem[12'h010] = 16'hABCD; mem[12'h012] = 16'h5555;
    apply_reset(3);
    n = 0;
    while (!o_we && n < 200) begin @(negedge clk); n++; end
    check("rw.we_seen", o_we, 1'b1);
    check("rw.data", o_data, 16'hABCD);
    #1 reset_n = 1'b0;
    #1;
    check("rw.we_drop", o_we, 1'b0);
    check("rw.ce_drop", o_ce, 1'b0);
    check("rw.addr_rst", o_addr, 12'h000);
    check("rw.ac_rst", o_ac, 16'h0000);
    repeat (3) @(negedge clk);
    check("rw.mem", mem[12'h012], 16'h5555);

    // LDA / ADD / STA / HLT, zero-wait
    clear_mem();
    mem[0] = 16'h2010; mem[1] = 16'h1011; mem[2] = 16'h3012; mem[3] = 16'h7001;
    mem[12'h010] = 16'hFFFF; mem[12'h011] = 16'h0002;
    run_case("prog", 0);
    check("prog.m012", mem[12'h012], 16'h0001);
    check("prog.e_const", o_e, 1'b1);
    check("prog.pc_const", o_pc, 12'h004);
    check("prog.cyc_const", last_cyc, 15);

    // LDA indirect with two wait states per access
    clear_mem();
    mem[0] = 16'hA020; mem[1] = 16'h7001;
    mem[12'h020] = 16'h0030; mem[12'h030] = 16'h1234;
    run_case("ldai", 2);
    check("ldai.ac_const", o_ac, 16'h1234);

    // ISZ rolling over to zero skips; non-zero result does not
    clear_mem();
    mem[0] = 16'h4005; mem[5] = 16'h6040; mem[6] = 16'h7001; mem[7] = 16'h7001;
    mem[12'h040] = 16'hFFFF;
    run_case("isz0", 1);
    check("isz0.m040", mem[12'h040], 16'h0000);
    check("isz0.pc_const", o_pc, 12'h008);
    clear_mem();
    mem[0] = 16'h4005; mem[5] = 16'h6040; mem[6] = 16'h7001; mem[7] = 16'h7001;
    mem[12'h040] = 16'h0003;
    run_case("isz3", 0);
    check("isz3.m040", mem[12'h040], 16'h0004);
    check("isz3.pc_const", o_pc, 12'h007);

    // BSA stores the return address; BUN indirect through a pointer
    clear_mem();
    mem[0] = 16'h4008; mem[8] = 16'h5050; mem[12'h051] = 16'h7001;
    run_case("bsa", 1);
    check("bsa.m050", mem[12'h050], 16'h0009);
    check("bsa.pc_const", o_pc, 12'h052);
    clear_mem();
    mem[0] = 16'hC060; mem[12'h060] = 16'h0100; mem[12'h100] = 16'h7001;
    run_case("buni", 0);
    check("buni.pc_const", o_pc, 12'h101);

    // Register-reference operations
    clear_mem();
    mem[0] = 16'h2010; mem[1] = 16'h7080; mem[2] = 16'h7001; mem[12'h010] = 16'h8001;
    run_case("cir", 0);
    check("cir.ac_const", o_ac, 16'h4000);
    check("cir.e_const", o_e, 1'b1);
    clear_mem();
    mem[0] = 16'h2010; mem[1] = 16'h7008; mem[2] = 16'h7001; mem[3] = 16'h7001;
    mem[12'h010] = 16'h8000;
    run_case("sna", 0);
    check("sna.pc_const", o_pc, 12'h004);
    clear_mem();
    mem[0] = 16'h7A00; mem[1] = 16'h7001;
    run_case("clacma", 0);
    check("clacma.ac_const", o_ac, 16'hFFFF);
    clear_mem();
    mem[0] = 16'h2010; mem[1] = 16'h7100; mem[2] = 16'h7020; mem[3] = 16'h7001;
    mem[12'h010] = 16'hFFFF;
    run_case("inc", 1);
    check("inc.ac_const", o_ac, 16'h0000);
    check("inc.e_const", o_e, 1'b1);

    // Random memory images, interpreted as programs, with random wait states
    for (int p = 0; p < 8; p++) begin
      int w;
      w = int'($urandom_range(2, 0));
      do begin
        for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);
        copy_mem();
        model_run(w, c, h);
      end while (!h);
      run_case($sformatf("rnd%0d", p), w);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
